z480_trap_stack: RTL and testbench

Parametrised nested-trap controller for the Z480 core, the successor to the single-level trap state block. It arbitrates several trap-raise sources by fixed priority and pushes cause, EPC and previous privilege mode onto a DEPTH-entry stack. Returns pop the stack and present the return PC and mode one cycle later. Overflowing the stack enters a sticky double-fault state. It sits between commit/execute, which raise traps, and the fetch redirect and CSR logic.

---
 rtl/z480_trap_pkg.sv | 24 ++
 rtl/z480_trap_prio_arb.sv | 26 ++
 rtl/z480_trap_stack.sv | 153 +++++++++++++++
 tb/tb_z480_trap_stack.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z480_trap_pkg.sv
// Shared types and constants for the Z480 nested trap controller.
// Entry field widths match the default top-level parameters.
package z480_trap_pkg;

  localparam int unsigned TRAP_XLEN    = 64;
  localparam int unsigned TRAP_CAUSE_W = 32;
  localparam int unsigned TRAP_MODE_W  = 2;

  // Cause code reported to the CSR file once the stack has overflowed.
  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_DOUBLE_FAULT = 32'h0000_0008;

  typedef struct packed {
    logic [TRAP_CAUSE_W-1:0] cause;
    logic [TRAP_XLEN-1:0]    epc;
    logic [TRAP_MODE_W-1:0]  prev_mode;
  } trap_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    FAULT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/z480_trap_prio_arb.sv
// Fixed-priority arbiter: lowest asserted request index wins.
// Produces a one-hot grant, the winning index and an any-request flag.
module z480_trap_prio_arb #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0]  req,
  output logic [NSRC-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (req[i] && !gnt_any) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z480_trap_stack.sv
// Nested trap controller: arbitrates raise sources, pushes {cause, epc, mode}
// onto a DEPTH-entry flop stack, pops on trap return, sticky double fault.
module z480_trap_stack
  import z480_trap_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned CAUSE_W = 32,
  parameter int unsigned NSRC    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MODE_W  = 2,
  parameter int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         raise_valid,
  input  logic [NSRC*CAUSE_W-1:0] raise_cause,
  input  logic [NSRC*XLEN-1:0]    raise_epc,
  output logic [NSRC-1:0]         raise_ack,
  input  logic [MODE_W-1:0]       cur_mode,
  input  logic                    ret_req,
  input  logic                    epc_we,
  input  logic [XLEN-1:0]         epc_wdata,
  output logic                    in_trap,
  output logic [LVL_W-1:0]        level,
  output logic [CAUSE_W-1:0]      cause,
  output logic [XLEN-1:0]         epc,
  output logic                    ret_valid,
  output logic [XLEN-1:0]         ret_pc,
  output logic [MODE_W-1:0]       ret_mode,
  output logic                    spurious_ret,
  output logic                    double_fault
);

  localparam int unsigned SIDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned TIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  trap_state_e        state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  trap_entry_t        stack_q [DEPTH];
  trap_entry_t        stack_d [DEPTH];
  logic               ret_valid_q, ret_valid_d;
  logic [XLEN-1:0]    ret_pc_q, ret_pc_d;
  logic [MODE_W-1:0]  ret_mode_q, ret_mode_d;
  logic               spurious_q, spurious_d;
  logic               dfault_q, dfault_d;

  logic [NSRC-1:0]    arb_gnt;
  logic [SIDX_W-1:0]  arb_idx;
  logic               arb_any;
  logic               grant;
  logic [TIDX_W-1:0]  top_idx;
  logic [TIDX_W-1:0]  push_idx;
  logic [CAUSE_W-1:0] sel_cause;
  logic [XLEN-1:0]    sel_epc;
  trap_entry_t        top_entry;

  z480_trap_prio_arb #(
    .NSRC  (NSRC),
    .IDX_W (SIDX_W)
  ) u_arb (
    .req     (raise_valid),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign grant     = arb_any && (state_q != FAULT);
  assign raise_ack = (state_q == FAULT) ? '0 : arb_gnt;

  assign sel_cause = raise_cause[int'(arb_idx)*CAUSE_W +: CAUSE_W];
  assign sel_epc   = raise_epc[int'(arb_idx)*XLEN +: XLEN];
  assign top_idx   = TIDX_W'(level_q - LVL_W'(1));
  assign push_idx  = TIDX_W'(level_q);
  assign top_entry = stack_q[top_idx];

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    stack_d     = stack_q;
    ret_valid_d = 1'b0;
    ret_pc_d    = ret_pc_q;
    ret_mode_d  = ret_mode_q;
    spurious_d  = 1'b0;
    dfault_d    = dfault_q;
    case (state_q)
      FAULT: ;
      default: begin
        // Priority: raise beats return, return beats a CSR epc write.
        if (grant) begin
          if (level_q == LVL_FULL) begin
            dfault_d = 1'b1;
            state_d  = FAULT;
          end else begin
            stack_d[push_idx].cause     = TRAP_CAUSE_W'(sel_cause);
            stack_d[push_idx].epc       = TRAP_XLEN'(sel_epc);
            stack_d[push_idx].prev_mode = TRAP_MODE_W'(cur_mode);
            level_d = level_q + LVL_W'(1);
            state_d = TRAP;
          end
        end else if (ret_req) begin
          if (level_q == '0) begin
            spurious_d = 1'b1;
          end else begin
            ret_valid_d = 1'b1;
            ret_pc_d    = XLEN'(top_entry.epc);
            ret_mode_d  = MODE_W'(top_entry.prev_mode);
            level_d     = level_q - LVL_W'(1);
            state_d     = (level_q == LVL_W'(1)) ? IDLE : TRAP;
          end
        end else if (epc_we && (level_q != '0)) begin
          stack_d[top_idx].epc = TRAP_XLEN'(epc_wdata);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_pc_q    <= '0;
      ret_mode_q  <= '0;
      spurious_q  <= 1'b0;
      dfault_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      ret_valid_q <= ret_valid_d;
      ret_pc_q    <= ret_pc_d;
      ret_mode_q  <= ret_mode_d;
      spurious_q  <= spurious_d;
      dfault_q    <= dfault_d;
    end
  end

  // Stack contents are don't-care after reset; level gates visibility.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign in_trap      = (level_q != '0);
  assign level        = level_q;
  assign cause        = in_trap ? CAUSE_W'(top_entry.cause) : '0;
  assign epc          = in_trap ? XLEN'(top_entry.epc) : '0;
  assign ret_valid    = ret_valid_q;
  assign ret_pc       = ret_pc_q;
  assign ret_mode     = ret_mode_q;
  assign spurious_ret = spurious_q;
  assign double_fault = dfault_q;

endmodule

// File: tb/tb_z480_trap_stack.sv
// Scoreboard bench for z480_trap_stack: a behavioural stack model queues the
// expected post-edge outputs each cycle; they are popped and compared after the edge.
module tb_z480_trap_stack;

  logic         clk;
  logic         rst;
  logic [3:0]   raise_valid;
  logic [127:0] raise_cause;
  logic [255:0] raise_epc;
  logic [3:0]   raise_ack;
  logic [1:0]   cur_mode;
  logic         ret_req;
  logic         epc_we;
  logic [63:0]  epc_wdata;
  logic         in_trap;
  logic [2:0]   level;
  logic [31:0]  cause;
  logic [63:0]  epc;
  logic         ret_valid;
  logic [63:0]  ret_pc;
  logic [1:0]   ret_mode;
  logic         spurious_ret;
  logic         double_fault;

  z480_trap_stack #(
    .XLEN    (64),
    .CAUSE_W (32),
    .NSRC    (4),
    .DEPTH   (4),
    .MODE_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raise_valid  (raise_valid),
    .raise_cause  (raise_cause),
    .raise_epc    (raise_epc),
    .raise_ack    (raise_ack),
    .cur_mode     (cur_mode),
    .ret_req      (ret_req),
    .epc_we       (epc_we),
    .epc_wdata    (epc_wdata),
    .in_trap      (in_trap),
    .level        (level),
    .cause        (cause),
    .epc          (epc),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_mode     (ret_mode),
    .spurious_ret (spurious_ret),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  level;
    logic        in_trap;
    logic [31:0] cause;
    logic [63:0] epc;
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  rmode;
    logic        sp;
    logic        df;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model
  logic [31:0] m_cause [4];
  logic [63:0] m_epc   [4];
  logic [1:0]  m_mode  [4];
  int          m_lvl   = 0;
  logic        m_fault = 1'b0;
  logic [63:0] m_rpc   = '0;
  logic [1:0]  m_rmode = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rst         = 1'b0;
    raise_valid = '0;
    raise_cause = '0;
    raise_epc   = '0;
    cur_mode    = '0;
    ret_req     = 1'b0;
    epc_we      = 1'b0;
    epc_wdata   = '0;
  endtask

  task automatic set_src(input int i, input logic [31:0] c, input logic [63:0] e);
    raise_valid[i]          = 1'b1;
    raise_cause[i*32 +: 32] = c;
    raise_epc[i*64 +: 64]   = e;
  endtask

  // Check the combinational grant, advance the model, queue the expected state,
  // clock once, then compare the DUT outputs against the queued entry.
  task automatic tick(input string tag);
    int          win;
    logic [3:0]  exp_ack;
    exp_t        e;
    exp_t        got;
    logic        rv;
    logic        sp;
    #1;
    win = -1;
    for (int i = 0; i < 4; i++) if (raise_valid[i] && win < 0) win = i;
    exp_ack = (m_fault || win < 0) ? 4'b0000 : 4'(1 << win);
    check({tag, ".ack"}, 64'(raise_ack), 64'(exp_ack));

    rv = 1'b0;
    sp = 1'b0;
    if (rst) begin
      m_lvl = 0; m_fault = 1'b0; m_rpc = '0; m_rmode = '0;
    end else if (!m_fault) begin
      if (win >= 0) begin
        if (m_lvl == 4) m_fault = 1'b1;
        else begin
          m_cause[m_lvl] = raise_cause[win*32 +: 32];
          m_epc[m_lvl]   = raise_epc[win*64 +: 64];
          m_mode[m_lvl]  = cur_mode;
          m_lvl++;
        end
      end else if (ret_req) begin
        if (m_lvl == 0) sp = 1'b1;
        else begin
          m_lvl--;
          rv = 1'b1;
          m_rpc   = m_epc[m_lvl];
          m_rmode = m_mode[m_lvl];
        end
      end else if (epc_we && m_lvl > 0) begin
        m_epc[m_lvl-1] = epc_wdata;
      end
    end
    e.level   = 3'(m_lvl);
    e.in_trap = (m_lvl != 0);
    e.cause   = (m_lvl != 0) ? m_cause[m_lvl-1] : '0;
    e.epc     = (m_lvl != 0) ? m_epc[m_lvl-1] : '0;
    e.rv      = rv;
    e.rpc     = m_rpc;
    e.rmode   = m_rmode;
    e.sp      = sp;
    e.df      = m_fault;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".level"},   64'(level),        64'(got.level));
    check({tag, ".in_trap"}, 64'(in_trap),      64'(got.in_trap));
    check({tag, ".cause"},   64'(cause),        64'(got.cause));
    check({tag, ".epc"},     epc,               got.epc);
    check({tag, ".rv"},      64'(ret_valid),    64'(got.rv));
    check({tag, ".rpc"},     ret_pc,            got.rpc);
    check({tag, ".rmode"},   64'(ret_mode),     64'(got.rmode));
    check({tag, ".sp"},      64'(spurious_ret), 64'(got.sp));
    check({tag, ".df"},      64'(double_fault), 64'(got.df));
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick("rst0");
    rst = 1'b1;
    tick("rst1");
    check("rst.level_const", 64'(level), 64'd0);

    // Single raise from source 2
    set_src(2, 32'h0D, 64'h1000); cur_mode = 2'd1;
    #1 check("src2.ack_const", 64'(raise_ack), 64'(4'b0100));
    tick("raise2");
    check("raise2.cause_const", 64'(cause), 64'h0D);
    ret_req = 1'b1;
    tick("ret2");

    // Sources 1 and 3 together
    set_src(1, 32'h11, 64'h2222_0000); set_src(3, 32'h33, 64'h3333_0000); cur_mode = 2'd3;
    tick("raise13");
    ret_req = 1'b1;
    tick("ret13");
    check("ret13.rpc_const", ret_pc, 64'h2222_0000);

    // Spurious return and dropped epc write at level 0
    ret_req = 1'b1;
    tick("spur");
    tick("spur_after");
    epc_we = 1'b1; epc_wdata = 64'hDEAD;
    tick("we_lvl0");

    // EPC overwrite at level 2
    set_src(0, 32'h01, 64'h4000); cur_mode = 2'd0;
    tick("l1");
    set_src(3, 32'h03, 64'h5000); cur_mode = 2'd1;
    tick("l2");
    epc_we = 1'b1; epc_wdata = 64'hFFFF_0000_0000_0040;
    tick("we_l2");
    check("we_l2.epc_const", epc, 64'hFFFF_0000_0000_0040);
    ret_req = 1'b1;
    tick("ret_we");
    ret_req = 1'b1;
    tick("ret_l1");
    check("ret_l1.rpc_const", ret_pc, 64'h4000);

    // Raise and return together at level 1, then reset
    set_src(1, 32'h21, 64'h6000);
    tick("rr_l1");
    set_src(2, 32'h22, 64'h7000); ret_req = 1'b1;
    tick("rr_same");
    rst = 1'b1;
    tick("rr_rst");

    // Overflow into double fault
    for (int i = 0; i < 5; i++) begin
      set_src(i % 4, 32'(i + 8'h40), 64'(64'h8000 + i * 16)); cur_mode = 2'(i);
      tick($sformatf("ovf%0d", i));
    end
    check("ovf.df_const", 64'(double_fault), 64'd1);
    set_src(0, 32'h99, 64'h9999);
    tick("fault_raise");
    ret_req = 1'b1;
    tick("fault_ret");
    epc_we = 1'b1; epc_wdata = 64'h1234;
    tick("fault_we");
    rst = 1'b1;
    tick("fault_rst");

    // Random mix
    for (int n = 0; n < 60; n++) begin
      raise_valid = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0);
      raise_cause = {$urandom, $urandom, $urandom, $urandom};
      raise_epc   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cur_mode    = 2'($urandom_range(0, 3));
      ret_req     = ($urandom_range(0, 2) == 0);
      epc_we      = ($urandom_range(0, 3) == 0);
      epc_wdata   = {$urandom, $urandom};
      rst         = ($urandom_range(0, 15) == 0);
      tick($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
